// File: rtl/capture_zone_arbiter.sv
// Capture-zone arbiter: samples per-tank zone presence once per frame, awards a one-cycle
// bonus to a tank that holds the zone alone long enough, then locks the zone for a cooldown.
module capture_zone_arbiter #(
  parameter int NUM_TANKS        = 2,
  parameter int FRAMES_PER_SEC   = 30,
  parameter int HOLD_SECONDS     = 5,
  parameter int COOLDOWN_SECONDS = 20,
  parameter int CONTEST_MODE     = 0,
  localparam int IDW = (NUM_TANKS > 2) ? $clog2(NUM_TANKS) : 1,
  localparam int SW  = $clog2(HOLD_SECONDS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_of_frame,
  input  logic                 clear,
  input  logic [NUM_TANKS-1:0] collision,
  output logic [NUM_TANKS-1:0] bonus,
  output logic [IDW-1:0]       winner_id,
  output logic                 winner_valid,
  output logic                 cooling_down,
  output logic [IDW-1:0]       holder_id,
  output logic                 holder_valid,
  output logic [SW-1:0]        hold_seconds
);

  localparam int FW      = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam int CD_LOAD = COOLDOWN_SECONDS * FRAMES_PER_SEC;
  localparam int CDW     = (CD_LOAD > 0) ? $clog2(CD_LOAD + 1) : 1;
  localparam logic [FW-1:0]  FRM_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [SW-1:0]  SEC_LAST = SW'(HOLD_SECONDS - 1);
  localparam logic [CDW-1:0] CD_INIT  = CDW'(CD_LOAD);

  typedef enum logic {ARMED = 1'b0, COOLDOWN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [NUM_TANKS-1:0] latch_q, latch_d;
  logic [FW-1:0]        frm_q [NUM_TANKS];
  logic [FW-1:0]        frm_d [NUM_TANKS];
  logic [SW-1:0]        sec_q [NUM_TANKS];
  logic [SW-1:0]        sec_d [NUM_TANKS];
  logic [CDW-1:0]       cd_q, cd_d;
  logic [NUM_TANKS-1:0] bonus_q, bonus_d;
  logic [IDW-1:0]       winner_id_q, winner_id_d;
  logic                 winner_valid_q, winner_valid_d;
  logic                 cooling_q, cooling_d;
  logic [IDW-1:0]       holder_id_q, holder_id_d;
  logic                 holder_valid_q, holder_valid_d;
  logic [SW-1:0]        hold_seconds_q, hold_seconds_d;

  logic [NUM_TANKS-1:0] pres;
  int unsigned          n_present;
  logic                 capture_hit;

  always_comb begin
    pres      = latch_q | collision;
    n_present = 0;
    for (int i = 0; i < NUM_TANKS; i++) n_present = n_present + {31'b0, pres[i]};

    state_d        = state_q;
    latch_d        = pres;
    frm_d          = frm_q;
    sec_d          = sec_q;
    cd_d           = cd_q;
    bonus_d        = '0;
    winner_id_d    = winner_id_q;
    winner_valid_d = winner_valid_q;
    holder_id_d    = holder_id_q;
    holder_valid_d = holder_valid_q;
    hold_seconds_d = hold_seconds_q;
    capture_hit    = 1'b0;

    if (clear) begin
      state_d        = ARMED;
      latch_d        = '0;
      cd_d           = '0;
      winner_id_d    = '0;
      winner_valid_d = 1'b0;
      holder_id_d    = '0;
      holder_valid_d = 1'b0;
      hold_seconds_d = '0;
      for (int i = 0; i < NUM_TANKS; i++) begin
        frm_d[i] = '0;
        sec_d[i] = '0;
      end
    end else if (start_of_frame) begin
      latch_d = '0;
      case (state_q)
        ARMED: begin
          holder_valid_d = 1'b0;
          holder_id_d    = '0;
          hold_seconds_d = '0;
          if (n_present == 1) begin
            for (int i = 0; i < NUM_TANKS; i++) begin
              if (pres[i]) begin
                holder_valid_d = 1'b1;
                holder_id_d    = IDW'(i);
                if (frm_q[i] != FRM_LAST) begin
                  frm_d[i]       = frm_q[i] + FW'(1);
                  hold_seconds_d = sec_q[i];
                end else if (sec_q[i] != SEC_LAST) begin
                  frm_d[i]       = '0;
                  sec_d[i]       = sec_q[i] + SW'(1);
                  hold_seconds_d = sec_d[i];
                end else begin
                  capture_hit    = 1'b1;
                  bonus_d[i]     = 1'b1;
                  winner_id_d    = IDW'(i);
                  winner_valid_d = 1'b1;
                end
              end else begin
                frm_d[i] = '0;
                sec_d[i] = '0;
              end
            end
            if (capture_hit) begin
              holder_valid_d = 1'b0;
              holder_id_d    = '0;
              hold_seconds_d = '0;
              for (int i = 0; i < NUM_TANKS; i++) begin
                frm_d[i] = '0;
                sec_d[i] = '0;
              end
              if (CD_LOAD > 0) begin
                state_d = COOLDOWN;
                cd_d    = CD_INIT;
              end
            end
          end else begin
            // Empty frames always reset progress; contested frames keep present tanks only in freeze mode
            for (int i = 0; i < NUM_TANKS; i++) begin
              if (n_present == 0 || CONTEST_MODE != 0 || !pres[i]) begin
                frm_d[i] = '0;
                sec_d[i] = '0;
              end
            end
          end
        end
        COOLDOWN: begin
          cd_d = cd_q - CDW'(1);
          if (cd_q == CDW'(1)) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
    cooling_d = (state_d == COOLDOWN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ARMED;
      latch_q        <= '0;
      cd_q           <= '0;
      bonus_q        <= '0;
      winner_id_q    <= '0;
      winner_valid_q <= 1'b0;
      cooling_q      <= 1'b0;
      holder_id_q    <= '0;
      holder_valid_q <= 1'b0;
      hold_seconds_q <= '0;
      for (int i = 0; i < NUM_TANKS; i++) begin
        frm_q[i] <= '0;
        sec_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      latch_q        <= latch_d;
      cd_q           <= cd_d;
      bonus_q        <= bonus_d;
      winner_id_q    <= winner_id_d;
      winner_valid_q <= winner_valid_d;
      cooling_q      <= cooling_d;
      holder_id_q    <= holder_id_d;
      holder_valid_q <= holder_valid_d;
      hold_seconds_q <= hold_seconds_d;
      for (int i = 0; i < NUM_TANKS; i++) begin
        frm_q[i] <= frm_d[i];
        sec_q[i] <= sec_d[i];
      end
    end
  end

  assign bonus        = bonus_q;
  assign winner_id    = winner_id_q;
  assign winner_valid = winner_valid_q;
  assign cooling_down = cooling_q;
  assign holder_id    = holder_id_q;
  assign holder_valid = holder_valid_q;
  assign hold_seconds = hold_seconds_q;

endmodule
